// File: rtl/dds_multi_ch.sv
// -----------------------------------------------------------------------------
// dds_multi_ch
//
// Parametrised N-channel DDS waveform core. Each channel has a phase
// accumulator, a phase offset, a selectable waveform (saw, triangle, square,
// DC) and an enable. Configuration is double-buffered: writes land in shadow
// registers and are committed to the active set of every channel at once by
// cfg_upd_i, so channels that are updated together stay phase-coherent.
//
// Pipeline:
//   acc   : phase accumulator (cleared by reset, phase_rst_i or disable)
//   stage1: p = top OUT_W bits of (acc + POW), with mode/enable/duty aligned
//   stage2: waveform shaping, registered into dds_o
// The accumulator value of cycle n appears on dds_o in cycle n+2.
//
// Ports:
//   sys_clk_i    system clock
//   sys_rst_i    synchronous reset, active-high
//   cfg_wr_i     shadow register write strobe
//   cfg_ch_i     target channel (out-of-range channels are ignored)
//   cfg_addr_i   register select: 0=FTW, 1=POW, 2=CTRL, 3=DUTY
//   cfg_data_i   write data, LSB-aligned for narrower registers
//   cfg_upd_i    commit all shadow registers to active, all channels
//   phase_rst_i  clear all accumulators
//   dds_o        packed unsigned offset-binary samples, channel k at
//                [k*OUT_W +: OUT_W]
//   sync_o       (only with DDS_SYNC_OUT_EN) per-channel one-cycle pulse
//                aligned with the sample whose accumulator update wrapped
//
// Optional feature macro: DDS_SYNC_OUT_EN (adds sync_o and its pipeline).
// -----------------------------------------------------------------------------
module dds_multi_ch #(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned CH_IDX_W = 1,
   parameter int unsigned PHASE_W  = 32,
   parameter int unsigned OUT_W    = 12
) (
   input  logic                      sys_clk_i,
   input  logic                      sys_rst_i,
   input  logic                      cfg_wr_i,
   input  logic [CH_IDX_W-1:0]       cfg_ch_i,
   input  logic [1:0]                cfg_addr_i,
   input  logic [PHASE_W-1:0]        cfg_data_i,
   input  logic                      cfg_upd_i,
   input  logic                      phase_rst_i,
   output logic [NUM_CH*OUT_W-1:0]   dds_o
`ifdef DDS_SYNC_OUT_EN
   ,
   output logic [NUM_CH-1:0]         sync_o
`endif
);

   localparam logic [1:0] AddrFtw  = 2'd0;
   localparam logic [1:0] AddrPow  = 2'd1;
   localparam logic [1:0] AddrCtrl = 2'd2;
   localparam logic [1:0] AddrDuty = 2'd3;

   localparam logic [OUT_W-1:0] MidScale = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ModeSaw    = 2'd0,
      ModeTri    = 2'd1,
      ModeSquare = 2'd2,
      ModeDc     = 2'd3
   } mode_e;

   // Shadow registers (written by cfg_wr_i)
   logic [PHASE_W-1:0] ftw_sh_d  [NUM_CH];
   logic [PHASE_W-1:0] ftw_sh_q  [NUM_CH];
   logic [PHASE_W-1:0] pow_sh_d  [NUM_CH];
   logic [PHASE_W-1:0] pow_sh_q  [NUM_CH];
   logic [2:0]         ctrl_sh_d [NUM_CH];
   logic [2:0]         ctrl_sh_q [NUM_CH];
   logic [OUT_W-1:0]   duty_sh_d [NUM_CH];
   logic [OUT_W-1:0]   duty_sh_q [NUM_CH];

   // Active registers (loaded by cfg_upd_i)
   logic [PHASE_W-1:0] ftw_act_d  [NUM_CH];
   logic [PHASE_W-1:0] ftw_act_q  [NUM_CH];
   logic [PHASE_W-1:0] pow_act_d  [NUM_CH];
   logic [PHASE_W-1:0] pow_act_q  [NUM_CH];
   logic [2:0]         ctrl_act_d [NUM_CH];
   logic [2:0]         ctrl_act_q [NUM_CH];
   logic [OUT_W-1:0]   duty_act_d [NUM_CH];
   logic [OUT_W-1:0]   duty_act_q [NUM_CH];

   // Accumulator stage
   logic [PHASE_W-1:0] acc_nxt [NUM_CH];
   logic [PHASE_W-1:0] acc_d   [NUM_CH];
   logic [PHASE_W-1:0] acc_q   [NUM_CH];

   // Stage 1: phase word plus aligned control
   logic [PHASE_W-1:0] ph_sum  [NUM_CH];
   logic [OUT_W-1:0]   p1_d    [NUM_CH];
   logic [OUT_W-1:0]   p1_q    [NUM_CH];
   mode_e              mode1_d [NUM_CH];
   mode_e              mode1_q [NUM_CH];
   logic [OUT_W-1:0]   duty1_d [NUM_CH];
   logic [OUT_W-1:0]   duty1_q [NUM_CH];
   logic [NUM_CH-1:0]  en1_d;
   logic [NUM_CH-1:0]  en1_q;

   // Stage 2: shaped samples
   logic [OUT_W-1:0]   tri_t   [NUM_CH];
   logic [OUT_W-1:0]   dds_d   [NUM_CH];
   logic [OUT_W-1:0]   dds_q   [NUM_CH];

   // ---------------------------------------------------------------------------
   // Shadow write decode and commit. A commit in the same cycle as a write
   // copies the old shadow value; the new value only reaches the shadow.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ftw_sh_d[k]  = ftw_sh_q[k];
         pow_sh_d[k]  = pow_sh_q[k];
         ctrl_sh_d[k] = ctrl_sh_q[k];
         duty_sh_d[k] = duty_sh_q[k];
         // Out-of-range channel numbers match no k and are dropped.
         if (cfg_wr_i && (cfg_ch_i == CH_IDX_W'(k))) begin
            case (cfg_addr_i)
               AddrFtw:  ftw_sh_d[k]  = cfg_data_i;
               AddrPow:  pow_sh_d[k]  = cfg_data_i;
               AddrCtrl: ctrl_sh_d[k] = cfg_data_i[2:0];
               AddrDuty: duty_sh_d[k] = cfg_data_i[OUT_W-1:0];
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ftw_act_d[k]  = ftw_act_q[k];
         pow_act_d[k]  = pow_act_q[k];
         ctrl_act_d[k] = ctrl_act_q[k];
         duty_act_d[k] = duty_act_q[k];
         if (cfg_upd_i) begin
            ftw_act_d[k]  = ftw_sh_q[k];
            pow_act_d[k]  = pow_sh_q[k];
            ctrl_act_d[k] = ctrl_sh_q[k];
            duty_act_d[k] = duty_sh_q[k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Accumulator. Wrap-around modulo 2^PHASE_W is silent.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         acc_nxt[k] = acc_q[k] + ftw_act_q[k];
         acc_d[k]   = acc_nxt[k];
         if (phase_rst_i || !ctrl_act_q[k][2]) begin
            acc_d[k] = '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: apply phase offset, keep control aligned with the phase word.
   // ---------------------------------------------------------------------------
   always_comb begin
      en1_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ph_sum[k]  = acc_q[k] + pow_act_q[k];
         p1_d[k]    = ph_sum[k][PHASE_W-1 -: OUT_W];
         mode1_d[k] = mode_e'(ctrl_act_q[k][1:0]);
         duty1_d[k] = duty_act_q[k];
         en1_d[k]   = ctrl_act_q[k][2];
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: waveform shaping.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         // Triangle: double the slope, fold the upper half downwards.
         tri_t[k] = {p1_q[k][OUT_W-2:0], 1'b0};
         dds_d[k] = MidScale;
         if (en1_q[k]) begin
            case (mode1_q[k])
               ModeSaw:    dds_d[k] = p1_q[k];
               ModeTri:    dds_d[k] = p1_q[k][OUT_W-1] ? ~tri_t[k] : tri_t[k];
               ModeSquare: dds_d[k] = (p1_q[k] < duty1_q[k]) ? {OUT_W{1'b1}}
                                                             : {OUT_W{1'b0}};
               ModeDc:     dds_d[k] = duty1_q[k];
               default:    dds_d[k] = MidScale;
            endcase
         end
      end
   end

   always_comb begin
      dds_o = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         dds_o[k*OUT_W +: OUT_W] = dds_q[k];
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            ftw_sh_q[k]   <= '0;
            pow_sh_q[k]   <= '0;
            ctrl_sh_q[k]  <= '0;
            duty_sh_q[k]  <= MidScale;
            ftw_act_q[k]  <= '0;
            pow_act_q[k]  <= '0;
            ctrl_act_q[k] <= '0;
            duty_act_q[k] <= MidScale;
            acc_q[k]      <= '0;
            p1_q[k]       <= '0;
            mode1_q[k]    <= ModeSaw;
            duty1_q[k]    <= MidScale;
            dds_q[k]      <= MidScale;
         end
         en1_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            ftw_sh_q[k]   <= ftw_sh_d[k];
            pow_sh_q[k]   <= pow_sh_d[k];
            ctrl_sh_q[k]  <= ctrl_sh_d[k];
            duty_sh_q[k]  <= duty_sh_d[k];
            ftw_act_q[k]  <= ftw_act_d[k];
            pow_act_q[k]  <= pow_act_d[k];
            ctrl_act_q[k] <= ctrl_act_d[k];
            duty_act_q[k] <= duty_act_d[k];
            acc_q[k]      <= acc_d[k];
            p1_q[k]       <= p1_d[k];
            mode1_q[k]    <= mode1_d[k];
            duty1_q[k]    <= duty1_d[k];
            dds_q[k]      <= dds_d[k];
         end
         en1_q <= en1_d;
      end
   end

`ifdef DDS_SYNC_OUT_EN
   // ---------------------------------------------------------------------------
   // Sync pulse: the carry is registered with the wrapped accumulator value and
   // follows it through both pipeline stages. Clears and disabled channels
   // never produce a carry.
   // ---------------------------------------------------------------------------
   logic [NUM_CH-1:0] carry_d;
   logic [NUM_CH-1:0] carry_q;
   logic [NUM_CH-1:0] carry1_d;
   logic [NUM_CH-1:0] carry1_q;
   logic [NUM_CH-1:0] sync_d;
   logic [NUM_CH-1:0] sync_q;

   always_comb begin
      carry_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!phase_rst_i && ctrl_act_q[k][2]) begin
            carry_d[k] = (acc_nxt[k] < acc_q[k]);
         end
      end
      carry1_d = carry_q;
      sync_d   = carry1_q & en1_q;
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         carry_q  <= '0;
         carry1_q <= '0;
         sync_q   <= '0;
      end else begin
         carry_q  <= carry_d;
         carry1_q <= carry1_d;
         sync_q   <= sync_d;
      end
   end

   assign sync_o = sync_q;
`else
   // Sync pipeline not built; dds_o behaviour is unchanged.
`endif

endmodule

// File: tb/tb_dds_multi_ch.sv
module tb_dds_multi_ch;

   logic        clk;
   logic        rst;
   logic        cfg_wr;
   logic [0:0]  cfg_ch;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_upd;
   logic        phase_rst;
   logic [23:0] dds;
`ifdef DDS_SYNC_OUT_EN
   logic [1:0]  sync;
`endif

   int errors = 0;
   int checks = 0;

   dds_multi_ch #(
      .NUM_CH   (2),
      .CH_IDX_W (1),
      .PHASE_W  (32),
      .OUT_W    (12)
   ) dut (
      .sys_clk_i   (clk),
      .sys_rst_i   (rst),
      .cfg_wr_i    (cfg_wr),
      .cfg_ch_i    (cfg_ch),
      .cfg_addr_i  (cfg_addr),
      .cfg_data_i  (cfg_data),
      .cfg_upd_i   (cfg_upd),
      .phase_rst_i (phase_rst),
      .dds_o       (dds)
`ifdef DDS_SYNC_OUT_EN
      ,
      .sync_o      (sync)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] lane(input int k);
      return dds[k*12 +: 12];
   endfunction

   // Advance one edge and settle; inputs set after this are seen at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int addr, input logic [31:0] data);
      cfg_wr   = 1'b1;
      cfg_ch   = 1'(ch);
      cfg_addr = 2'(addr);
      cfg_data = data;
      tick();
      cfg_wr   = 1'b0;
   endtask

   // Commit, then wait until the first sample from the new settings is on dds.
   task automatic commit(input logic prst);
      cfg_upd   = 1'b1;
      phase_rst = prst;
      tick();
      cfg_upd   = 1'b0;
      phase_rst = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (lane(k) !== 12'd2048) begin
               errors++;
               $display("FAIL reset_mid lane%0d i=%0d got=%0d exp=2048", k, i, lane(k));
            end
         end
         tick();
      end
      // Shadow writes alone must not change the output.
      wr(0, 0, 32'h1000_0000);
      wr(0, 2, 32'h4);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (lane(0) !== 12'd2048) begin
            errors++;
            $display("FAIL shadow_only lane0 i=%0d got=%0d exp=2048", i, lane(0));
         end
         tick();
      end
   endtask

   task automatic test_saw();
      logic [11:0] exp0;
      wr(0, 0, 32'h1000_0000);
      wr(0, 2, 32'h4);
      commit(1'b0);
      for (int i = 0; i < 32; i++) begin
         exp0 = 12'((i % 16) * 256);
         checks++;
         if (lane(0) !== exp0) begin
            errors++;
            $display("FAIL saw lane0 i=%0d got=%0d exp=%0d", i, lane(0), exp0);
         end
         checks++;
         if (lane(1) !== 12'd2048) begin
            errors++;
            $display("FAIL saw lane1_idle i=%0d got=%0d exp=2048", i, lane(1));
         end
         tick();
      end
   endtask

   task automatic test_triangle();
      logic [11:0] exp0;
      int          j;
      wr(0, 2, 32'h5);
      commit(1'b1);
      for (int i = 0; i < 32; i++) begin
         j = i % 16;
         exp0 = (j < 8) ? 12'(j * 512) : 12'(4095 - (j - 8) * 512);
         checks++;
         if (lane(0) !== exp0) begin
            errors++;
            $display("FAIL triangle lane0 i=%0d got=%0d exp=%0d", i, lane(0), exp0);
         end
         tick();
      end
   endtask

   task automatic test_square();
      logic [11:0] exp1;
      wr(1, 0, 32'h1000_0000);
      wr(1, 3, 32'd1024);
      wr(1, 2, 32'h6);
      commit(1'b1);
      for (int i = 0; i < 32; i++) begin
         exp1 = ((i % 16) < 4) ? 12'd4095 : 12'd0;
         checks++;
         if (lane(1) !== exp1) begin
            errors++;
            $display("FAIL square lane1 i=%0d got=%0d exp=%0d", i, lane(1), exp1);
         end
         tick();
      end
   endtask

   task automatic test_pow();
      logic [11:0] exp0;
      logic [11:0] exp1;
      wr(0, 2, 32'h4);
      wr(1, 2, 32'h4);
      wr(1, 1, 32'h8000_0000);
      commit(1'b1);
      for (int i = 0; i < 20; i++) begin
         exp0 = 12'((i % 16) * 256);
         exp1 = 12'(((i % 16) * 256 + 2048) % 4096);
         checks++;
         if (lane(0) !== exp0) begin
            errors++;
            $display("FAIL pow lane0 i=%0d got=%0d exp=%0d", i, lane(0), exp0);
         end
         checks++;
         if (lane(1) !== exp1) begin
            errors++;
            $display("FAIL pow lane1 i=%0d got=%0d exp=%0d", i, lane(1), exp1);
         end
         tick();
      end
   endtask

   // Write and commit in the same cycle: the old FTW is committed.
   task automatic test_wr_upd_same();
      logic [11:0] exp0;
      cfg_wr    = 1'b1;
      cfg_ch    = 1'b0;
      cfg_addr  = 2'd0;
      cfg_data  = 32'h2000_0000;
      cfg_upd   = 1'b1;
      phase_rst = 1'b1;
      tick();
      cfg_wr    = 1'b0;
      cfg_upd   = 1'b0;
      phase_rst = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 16; i++) begin
         exp0 = 12'(i * 256);
         checks++;
         if (lane(0) !== exp0) begin
            errors++;
            $display("FAIL wr_upd_old lane0 i=%0d got=%0d exp=%0d", i, lane(0), exp0);
         end
         tick();
      end
      commit(1'b1);
      for (int i = 0; i < 16; i++) begin
         exp0 = 12'((i * 512) % 4096);
         checks++;
         if (lane(0) !== exp0) begin
            errors++;
            $display("FAIL wr_upd_new lane0 i=%0d got=%0d exp=%0d", i, lane(0), exp0);
         end
         tick();
      end
   endtask

   // DC mode with an oversized DUTY write (truncated to 12 bits: 0x123).
   task automatic test_dc();
      wr(1, 3, 32'hFFFF_F123);
      wr(1, 2, 32'h7);
      commit(1'b0);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (lane(1) !== 12'h123) begin
            errors++;
            $display("FAIL dc lane1 i=%0d got=%0d exp=%0d", i, lane(1), 12'h123);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (lane(k) !== 12'd2048) begin
            errors++;
            $display("FAIL reset_edge lane%0d got=%0d exp=2048", k, lane(k));
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (lane(0) !== 12'd2048) begin
            errors++;
            $display("FAIL reset_after lane0 i=%0d got=%0d exp=2048", i, lane(0));
         end
      end
      commit(1'b0);
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (lane(k) !== 12'd2048) begin
               errors++;
               $display("FAIL reset_upd lane%0d i=%0d got=%0d exp=2048", k, i, lane(k));
            end
         end
         tick();
      end
   endtask

`ifdef DDS_SYNC_OUT_EN
   task automatic test_sync();
      logic exp_s;
      wr(0, 0, 32'h1000_0000);
      wr(0, 2, 32'h4);
      commit(1'b1);
      for (int i = 0; i < 34; i++) begin
         exp_s = ((i % 16) == 0) && (i != 0);
         checks++;
         if (sync[0] !== exp_s) begin
            errors++;
            $display("FAIL sync0 i=%0d got=%0b exp=%0b lane0=%0d", i, sync[0], exp_s, lane(0));
         end
         checks++;
         if (sync[1] !== 1'b0) begin
            errors++;
            $display("FAIL sync1_idle i=%0d got=%0b exp=0", i, sync[1]);
         end
         tick();
      end
   endtask
`endif

   initial begin
      rst       = 1'b1;
      cfg_wr    = 1'b0;
      cfg_ch    = 1'b0;
      cfg_addr  = 2'd0;
      cfg_data  = 32'd0;
      cfg_upd   = 1'b0;
      phase_rst = 1'b0;
      test_reset();
      test_saw();
      test_triangle();
      test_square();
      test_pow();
      test_wr_upd_same();
      test_dc();
      test_reset_mid();
`ifdef DDS_SYNC_OUT_EN
      test_sync();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
